// File: rtl/y86_instr_encoder.sv
// Y86-64 program loader: encodes decoded instruction fields into bytes and writes them one per cycle.
// Latency: first byte one cycle after accept, len+1 cycles per instruction; in_ready low while emitting.
module y86_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              instr_done,
  output logic [ADDR_W-1:0] next_addr,
  output logic              err_invalid,
  output logic              err_overflow
);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  // Zero length marks an icode with no encoding.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic [7:0]        regs_q, regs_d;
  logic [63:0]       valc_q, valc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_inv_q, err_inv_d;
  logic              err_ovf_q, err_ovf_d;

  logic [3:0]        acc_len;
  logic [ADDR_W:0]   acc_end;
  logic [3:0]        nxt_idx;
  logic [2:0]        vbyte;
  logic [7:0]        nxt_byte;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    len_d       = len_q;
    regs_d      = regs_q;
    valc_d      = valc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_inv_d   = 1'b0;
    err_ovf_d   = 1'b0;

    in_ready = (state_q == IDLE) && !base_load;
    acc_len  = instr_len(in_icode);
    // One extra bit keeps ptr+len from wrapping past the top of memory.
    acc_end  = ptr_q + (ADDR_W+1)'(acc_len);
    nxt_idx  = idx_q + 4'd1;

    // Register byte sits at index 1 unless the format has no register byte (len 9).
    vbyte    = 3'(nxt_idx - ((len_q == 4'd10) ? 4'd2 : 4'd1));
    if (nxt_idx == 4'd1 && len_q != 4'd9) nxt_byte = regs_q;
    else                                   nxt_byte = valc_q[{vbyte, 3'b000} +: 8];

    case (state_q)
      IDLE: begin
        if (base_load) begin
          ptr_d = {1'b0, base_addr};
        end else if (in_valid) begin
          if (acc_len == 4'd0) begin
            err_inv_d = 1'b1;
          end else if (acc_end > MEM_LIM) begin
            err_ovf_d = 1'b1;
          end else begin
            state_d     = EMIT;
            idx_d       = 4'd0;
            len_d       = acc_len;
            regs_d      = {in_rA, in_rB};
            valc_d      = in_valC;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q[ADDR_W-1:0];
            mem_wdata_d = {in_icode, in_ifun};
            done_d      = (acc_len == 4'd1);
          end
        end
      end
      EMIT: begin
        if (idx_q == len_q - 4'd1) begin
          state_d = IDLE;
          ptr_d   = ptr_q + (ADDR_W+1)'(len_q);
        end else begin
          idx_d       = nxt_idx;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q[ADDR_W-1:0] + ADDR_W'(nxt_idx);
          mem_wdata_d = nxt_byte;
          done_d      = (nxt_idx == len_q - 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      regs_q      <= '0;
      valc_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_inv_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      regs_q      <= regs_d;
      valc_q      <= valc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_inv_q   <= err_inv_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // A pointer of exactly MEM_BYTES reads back as its low ADDR_W bits.
  assign next_addr    = ptr_q[ADDR_W-1:0];
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign instr_done   = done_q;
  assign err_invalid  = err_inv_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Directed bench for y86_instr_encoder: hand-computed byte streams, pointer and error pulses.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        base_load = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_icode = '0, in_ifun = '0, in_rA = '0, in_rB = '0;
  logic [63:0] in_valC = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        instr_done;
  logic [9:0]  next_addr;
  logic        err_invalid, err_overflow;

  int checks = 0;
  int passed = 0;

  logic       cap_we [12];
  logic [9:0] cap_addr [12];
  logic [7:0] cap_data [12];
  logic       cap_done [12];
  logic       cap_rdy [12];
  logic       cap_einv [12];
  logic       cap_eovf [12];
  logic [9:0] cap_next [12];

  y86_instr_encoder #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .instr_done(instr_done),
    .next_addr(next_addr), .err_invalid(err_invalid), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Presents one instruction, then records n negedge samples starting the cycle after accept.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] c, input int n);
    int t;
    @(negedge clk);
    in_icode = ic; in_ifun = fn; in_rA = ra; in_rB = rb; in_valC = c; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) $display("FAIL accept_timeout icode=%h in_ready=%b want 1", ic, in_ready);
    else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_we[i] = mem_we; cap_addr[i] = mem_addr; cap_data[i] = mem_wdata;
      cap_done[i] = instr_done; cap_rdy[i] = in_ready; cap_einv[i] = err_invalid;
      cap_eovf[i] = err_overflow; cap_next[i] = next_addr;
    end
  endtask

  task automatic load_base(input logic [9:0] a);
    @(negedge clk);
    base_load = 1'b1; base_addr = a;
    @(posedge clk);
    #1 base_load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, instr_done, err_invalid, err_overflow, next_addr} !== '0)
      $display("FAIL reset_outputs we=%b addr=%h data=%h done=%b einv=%b eovf=%b next=%h want all 0",
               mem_we, mem_addr, mem_wdata, instr_done, err_invalid, err_overflow, next_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_halt;
    run_instr(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 2);
    checks++;
    if (cap_we[0] !== 1'b1 || cap_addr[0] !== 10'd0 || cap_data[0] !== 8'h00 || cap_done[0] !== 1'b1)
      $display("FAIL halt_write we=%b addr=%h data=%h done=%b want 1 000 00 1",
               cap_we[0], cap_addr[0], cap_data[0], cap_done[0]);
    else passed++;
    checks++;
    if (cap_we[1] !== 1'b0 || cap_next[1] !== 10'd1 || cap_rdy[1] !== 1'b1)
      $display("FAIL halt_after we=%b next=%h rdy=%b want 0 001 1", cap_we[1], cap_next[1], cap_rdy[1]);
    else passed++;
  endtask

  task automatic test_irmovq;
    logic [7:0] exp [10];
    exp = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    load_base(10'd0);
    run_instr(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 11);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap_we[i] !== 1'b1 || cap_addr[i] !== 10'(i) || cap_data[i] !== exp[i] ||
          cap_done[i] !== (i == 9) || cap_rdy[i] !== 1'b0)
        $display("FAIL irmovq_byte%0d we=%b addr=%h data=%h done=%b rdy=%b want 1 %h %h %b 0",
                 i, cap_we[i], cap_addr[i], cap_data[i], cap_done[i], cap_rdy[i], 10'(i), exp[i], i == 9);
      else passed++;
    end
    checks++;
    if (cap_we[10] !== 1'b0 || cap_next[10] !== 10'd10 || cap_rdy[10] !== 1'b1)
      $display("FAIL irmovq_after we=%b next=%h rdy=%b want 0 00a 1", cap_we[10], cap_next[10], cap_rdy[10]);
    else passed++;
  endtask

  task automatic test_jmp_ret;
    logic [7:0] exp [9];
    exp = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_base(10'h100);
    run_instr(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 9);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (cap_we[i] !== 1'b1 || cap_addr[i] !== 10'(10'h100 + i) || cap_data[i] !== exp[i] ||
          cap_done[i] !== (i == 8))
        $display("FAIL jmp_byte%0d we=%b addr=%h data=%h done=%b want 1 %h %h %b",
                 i, cap_we[i], cap_addr[i], cap_data[i], cap_done[i], 10'(10'h100 + i), exp[i], i == 8);
      else passed++;
    end
    run_instr(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 2);
    checks++;
    if (cap_we[0] !== 1'b1 || cap_addr[0] !== 10'h109 || cap_data[0] !== 8'h90 || cap_done[0] !== 1'b1)
      $display("FAIL ret_write we=%b addr=%h data=%h done=%b want 1 109 90 1",
               cap_we[0], cap_addr[0], cap_data[0], cap_done[0]);
    else passed++;
    checks++;
    if (cap_next[1] !== 10'h10A) $display("FAIL ret_next got=%h want 10a", cap_next[1]);
    else passed++;
  endtask

  task automatic test_invalid;
    run_instr(4'hC, 4'h0, 4'h1, 4'h2, 64'h55, 3);
    checks++;
    if (cap_einv[0] !== 1'b1 || cap_einv[1] !== 1'b0 || cap_eovf[0] !== 1'b0)
      $display("FAIL invalid_pulse einv=%b,%b eovf=%b want 1,0 0", cap_einv[0], cap_einv[1], cap_eovf[0]);
    else passed++;
    checks++;
    if ((cap_we[0] | cap_we[1] | cap_we[2]) !== 1'b0 || cap_next[2] !== 10'h10A || cap_rdy[2] !== 1'b1)
      $display("FAIL invalid_nowrite we=%b%b%b next=%h rdy=%b want 000 10a 1",
               cap_we[0], cap_we[1], cap_we[2], cap_next[2], cap_rdy[2]);
    else passed++;
  endtask

  task automatic test_overflow;
    load_base(10'd1020);
    run_instr(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 3);
    checks++;
    if (cap_eovf[0] !== 1'b1 || cap_eovf[1] !== 1'b0 || cap_einv[0] !== 1'b0)
      $display("FAIL ovf_pulse eovf=%b,%b einv=%b want 1,0 0", cap_eovf[0], cap_eovf[1], cap_einv[0]);
    else passed++;
    checks++;
    if ((cap_we[0] | cap_we[1] | cap_we[2]) !== 1'b0 || cap_next[2] !== 10'd1020)
      $display("FAIL ovf_nowrite we=%b%b%b next=%0d want 000 1020",
               cap_we[0], cap_we[1], cap_we[2], cap_next[2]);
    else passed++;
    load_base(10'd1014);
    run_instr(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 11);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap_we[i] !== 1'b1 || cap_addr[i] !== 10'(1014 + i) || cap_eovf[i] !== 1'b0)
        $display("FAIL fill_byte%0d we=%b addr=%0d eovf=%b want 1 %0d 0",
                 i, cap_we[i], cap_addr[i], cap_eovf[i], 1014 + i);
      else passed++;
    end
    // Pointer of 1024 reads back as 0 on the 10-bit port.
    checks++;
    if (cap_next[10] !== 10'd0 || cap_we[10] !== 1'b0)
      $display("FAIL fill_next next=%0d we=%b want 0 0", cap_next[10], cap_we[10]);
    else passed++;
    run_instr(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 2);
    checks++;
    if (cap_eovf[0] !== 1'b1 || cap_we[0] !== 1'b0)
      $display("FAIL full_halt eovf=%b we=%b want 1 0", cap_eovf[0], cap_we[0]);
    else passed++;
  endtask

  task automatic test_reset_mid;
    load_base(10'd0);
    run_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 5);
    checks++;
    if (cap_we[4] !== 1'b1 || cap_addr[4] !== 10'd4 || cap_data[4] !== 8'h66 || cap_data[1] !== 8'h12)
      $display("FAIL rmmovq_prefix we=%b addr=%h data4=%h data1=%h want 1 004 66 12",
               cap_we[4], cap_addr[4], cap_data[4], cap_data[1]);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, instr_done, next_addr} !== '0)
      $display("FAIL midreset_clear we=%b addr=%h data=%h done=%b next=%h want all 0",
               mem_we, mem_addr, mem_wdata, instr_done, next_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) $display("FAIL midreset_ready rdy=%b we=%b want 1 0", in_ready, mem_we);
    else passed++;
    base_load = 1'b1; base_addr = 10'h200; in_valid = 1'b1;
    in_icode = 4'h0; in_ifun = 4'h0;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL baseload_ready got=%b want 0", in_ready);
    else passed++;
    @(posedge clk);
    #1 base_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || next_addr !== 10'h200)
      $display("FAIL baseload_noaccept we=%b next=%h want 0 200", mem_we, next_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || next_addr !== 10'h200)
      $display("FAIL baseload_quiet we=%b next=%h want 0 200", mem_we, next_addr);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_halt();
    test_irmovq();
    test_jmp_ret();
    test_invalid();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
